fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; power of two, >= 2.
REQ-002 Parameter ADDR_WIDTH, default sp_pkg ADDR_WIDTH, PC width.
REQ-003 Parameter DATA_WIDTH, default sp_pkg DATA_WIDTH, instruction width.
REQ-004 clk_i  in  1  clock; all state updates on rising edge.
REQ-005 arst_ni  in  1  reset, asynchronous, active-low.
REQ-006 flush_i  in  1  synchronous discard of all entries (redirect/branch).
REQ-007 in_valid_i  in  1  fetch stage offers a {pc, instruction} pair.
REQ-008 in_pc_i  in  ADDR_WIDTH  PC of offered instruction.
REQ-009 in_instr_i  in  DATA_WIDTH  offered instruction word.
REQ-010 in_ready_o  out  1  queue accepts a pair this cycle.
REQ-011 out_valid_o  out  1  head entry available to decode.
REQ-012 out_pc_o  out  ADDR_WIDTH  PC of head entry.
REQ-013 out_instr_o  out  DATA_WIDTH  instruction of head entry.
REQ-014 out_ready_i  in  1  decode consumes head entry this cycle.
REQ-015 count_o  out  $clog2(DEPTH+1)  number of occupied entries.
REQ-016 full_o / empty_o  out  1 each  count_o == DEPTH / count_o == 0.

Function
REQ-017 Push occurs when in_valid_i && in_ready_o; pop occurs when out_valid_o && out_ready_i.
REQ-018 in_ready_o SHALL equal (count_o < DEPTH); no combinational path from out_ready_i to in_ready_o.
REQ-019 out_valid_o SHALL equal (count_o != 0).
REQ-020 out_pc_o/out_instr_o SHALL be driven from storage at read pointer when out_valid_o=1, else '0.
REQ-021 Pushed pair SHALL appear at head no earlier than the cycle after the push edge (1-cycle latency when empty).
REQ-022 Entries SHALL be delivered strictly in push order; no loss, duplication, or reorder.
REQ-023 Write/read pointers SHALL increment by 1 per push/pop and wrap from DEPTH-1 to 0.
REQ-024 Simultaneous push and pop (0 < count < DEPTH): count unchanged, both pointers advance.
REQ-025 When full, in_ready_o=0; in_valid_i ignored even if pop occurs same cycle; in_ready_o rises the cycle after the pop.
REQ-026 When empty, out_ready_i ignored; count never underflows.
REQ-027 in_valid_i while in_ready_o=0 SHALL NOT change state; upstream holds data.
REQ-028 flush_i=1 SHALL take priority: next edge sets both pointers and count to 0, discarding any same-cycle push and pop.
REQ-029 Stored data contents need not be cleared by flush or reset; only visibility via count.
REQ-030 count_o, full_o, empty_o SHALL be registered-state derived, glitch-free relative to inputs.

Reset
REQ-031 arst_ni low SHALL immediately clear pointers and count: count_o=0, empty_o=1, full_o=0, out_valid_o=0, in_ready_o=1, out_pc_o='0, out_instr_o='0.
REQ-032 Reset asserted mid-operation SHALL discard all entries; first push after release is first entry delivered.
REQ-033 Outputs SHALL be known (no X) from reset assertion onward.

Verification
REQ-034 Reset then push pc=0x0/instr=0x1111, out_ready_i=0 -> next cycle out_valid_o=1, out_pc_o=0x0, out_instr_o=0x1111, count_o=1.
REQ-035 DEPTH=4, push pc=0,2,4,6 with out_ready_i=0 -> full_o=1, in_ready_o=0; 5th offer pc=8 held; pops return 0,2,4,6 then pc=8 accepted after first pop.
REQ-036 Continuous push+pop for 10 cycles starting count=2 -> count_o stays 2, pointers wrap, output order matches input order.
REQ-037 count=3, flush_i=1 with in_valid_i=1 and out_ready_i=1 same cycle -> next cycle count_o=0, empty_o=1, pushed pair absent.
REQ-038 count=2, arst_ni pulsed low between edges -> outputs immediately at reset values; subsequent push pc=0x10 delivered first.
REQ-039 Empty queue, out_ready_i=1 for 3 cycles, no push -> count_o stays 0, out_valid_o=0, out_pc_o=0.

Source files
------------

// File: rtl/sp_pkg.sv
// Shared widths for the processor datapath.
package sp_pkg;
    parameter int unsigned ADDR_WIDTH = 32;
    parameter int unsigned DATA_WIDTH = 32;
endpackage

// File: rtl/fetch_queue.sv
// Instruction fetch queue: in-order FIFO of {pc, instruction} pairs between fetch and decode.
// Flush discards every entry on the next edge; stored words are never cleared, only hidden by count.
module fetch_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = sp_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = sp_pkg::DATA_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         arst_ni,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    input  logic [ADDR_WIDTH-1:0]        in_pc_i,
    input  logic [DATA_WIDTH-1:0]        in_instr_i,
    output logic                         in_ready_o,
    output logic                         out_valid_o,
    output logic [ADDR_WIDTH-1:0]        out_pc_o,
    output logic [DATA_WIDTH-1:0]        out_instr_o,
    input  logic                         out_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    // Handshake flags depend only on registered count, so out_ready_i never reaches in_ready_o.
    assign in_ready_o  = (count_q < DEPTH_C);
    assign out_valid_o = (count_q != '0);
    assign full_o      = (count_q == DEPTH_C);
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;

    assign push = in_valid_i && in_ready_o;
    assign pop  = out_valid_o && out_ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap to 0.
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{pc: in_pc_i, instr: in_instr_i};
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign head        = mem_q[rd_ptr_q];
    assign out_pc_o    = out_valid_o ? head.pc    : '0;
    assign out_instr_o = out_valid_o ? head.instr : '0;

endmodule
